alu_control_dec: RTL and testbench
==================================

# alu_control_dec

Decodes the main-control ALU operation class (`aluop`) and the instruction `funct7`/`funct3` fields into the 4-bit operation select driven into the ALU. It sits in the execute stage between the main control unit and the ALU. The decoded select is combinational for same-cycle use. A registered copy and illegal-encoding flags are also provided for pipeline and debug use.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `aluop`  in  2  operation class from main control.
- `funct7`  in  7  instruction bits [31:25].
- `funct3`  in  3  instruction bits [14:12].
- `alu_control`  out  4  combinational ALU operation select.
- `illegal`  out  1  combinational flag: current field combination is not a legal encoding.
- `alu_control_q`  out  4  `alu_control` registered on `clk`.
- `illegal_q`  out  1  `illegal` registered on `clk`.
- `illegal_sticky`  out  1  set by any registered illegal decode; cleared only by `rst`.

## Operation
- Select encodings:
  - AND=0000, OR=0001, ADD=0010, SLL=0011, XOR=0100.
  - SRL=0101, SUB=0110, SLT=0111, SRA=1000, SLTU=1001.
  - 1010–1111 are never produced.
- `aluop`=00 (load/store address): ADD. `funct7`/`funct3` are ignored, even when X/Z. Output must be a clean 0010 and `illegal`=0.
- `aluop`=01 (branch compare): SUB, fields ignored as above, `illegal`=0.
- `aluop`=10 (R-type), decoded on `funct3`:
  - `funct3`=000: ADD if `funct7`=0000000; SUB if `funct7`=0100000.
  - `funct3`=001: SLL.
  - `funct3`=010: SLT.
  - `funct3`=011: SLTU.
  - `funct3`=100: XOR.
  - `funct3`=101: SRL if `funct7`=0000000; SRA if `funct7`=0100000.
  - `funct3`=110: OR.
  - `funct3`=111: AND.
  - For `funct3` other than 000/101, `funct7` must be 0000000.
- `aluop`=11 (I-type ALU), decoded on `funct3`:
  - `funct3`=000: ADD. No SUB; `funct7` ignored.
  - `funct3`=010/011/100/110/111: SLT/SLTU/XOR/OR/AND, `funct7` ignored.
  - `funct3`=001: SLL; requires `funct7`=0000000.
  - `funct3`=101: SRL or SRA; `funct7` rule as for R-type.
- Any combination not listed above (e.g. R-type `funct7`=0000001):
  - `alu_control`=ADD (0010) and `illegal`=1.
  - Only `funct7`=0000000 or 0100000 are recognised.
- X/Z on any field that the current `aluop` consults: output is don't-care, but no X may reach `alu_control` when `aluop` is 00 or 01.

## Timing
- `alu_control` and `illegal` are purely combinational from inputs; zero-cycle latency.
- `alu_control_q`/`illegal_q` update every rising `clk` edge; one-cycle latency.
- `illegal_sticky` sets in the cycle `illegal_q` would become 1 (same edge) and holds until reset.
- Reset (synchronous, `rst`=1 at a rising edge):
  - `alu_control_q`=0010.
  - `illegal_q`=0.
  - `illegal_sticky`=0.
  - Reset wins over a simultaneous illegal decode.
- Combinational outputs are unaffected by `rst`.

## Configuration
- `ALU_CTRL_EXT_EN` defined: full decode as above.
- Not defined: only ADD, SUB, AND and OR are produced.
  - R-type legal: `funct3`=000 (ADD/SUB per `funct7`), 110 with `funct7`=0000000, 111 with `funct7`=0000000.
  - I-type legal: `funct3` 000, 110, 111.
  - Every other R/I-type encoding → ADD with `illegal`=1.
  - `aluop` 00/01 unchanged.

## Test plan
- `aluop`=00, `funct7`/`funct3`=X → `alu_control`=0010, `illegal`=0; `aluop`=01, fields X → 0110.
- `aluop`=10:
  - `funct7`=0000000, `funct3`=000 → 0010; `funct7`=0100000, `funct3`=000 → 0110.
  - `funct7`=0000000, `funct3`=111 → 0000; `funct3`=110 → 0001.
- With `ALU_CTRL_EXT_EN`:
  - R-type `funct3`=101, `funct7`=0100000 → 1000.
  - I-type `funct3`=000, `funct7`=0100000 → 0010.
  - R-type `funct3`=011 → 1001.
- R-type `funct7`=0000001, `funct3`=000 → `alu_control`=0010, `illegal`=1; after next edge `illegal_q`=1 and `illegal_sticky`=1; sticky stays 1 after a legal decode until `rst`.
- Assert `rst` for one edge during an illegal decode → `alu_control_q`=0010, `illegal_q`=0, `illegal_sticky`=0; `alu_control` still tracks inputs combinationally.
- Without `ALU_CTRL_EXT_EN`: R-type `funct3`=100 → 0010 with `illegal`=1.

Source files
------------

// File: rtl/alu_control_dec.sv
// rtl/alu_control_dec.sv - ALU operation select decode from aluop/funct7/funct3
// Optional macro ALU_CTRL_EXT_EN enables shifts, compares and XOR; otherwise only ADD/SUB/AND/OR.
module alu_control_dec (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] aluop,
   input  logic [6:0] funct7,
   input  logic [2:0] funct3,
   output logic [3:0] alu_control,
   output logic       illegal,
   output logic [3:0] alu_control_q,
   output logic       illegal_q,
   output logic       illegal_sticky
);

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
`ifdef ALU_CTRL_EXT_EN
   localparam logic [3:0] ALU_SLL  = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;
`endif

   logic       f7_zero;
   logic       f7_alt;
   logic [3:0] ctrl_d;
   logic       illegal_d;
   logic [3:0] ctrl_q;
   logic       illegal_r_q;
   logic       sticky_q;
   logic       sticky_d;

   assign f7_zero = (funct7 == 7'b0000000);
   assign f7_alt  = (funct7 == 7'b0100000);

   // Load/store and branch classes never look at the funct fields, so X there cannot leak out.
   always_comb begin
      ctrl_d    = ALU_ADD;
      illegal_d = 1'b0;
      case (aluop)
         2'b00: ctrl_d = ALU_ADD;
         2'b01: ctrl_d = ALU_SUB;
         2'b10: begin
            case (funct3)
               3'b000: begin
                  if (f7_zero)     ctrl_d = ALU_ADD;
                  else if (f7_alt) ctrl_d = ALU_SUB;
                  else             illegal_d = 1'b1;
               end
`ifdef ALU_CTRL_EXT_EN
               3'b001: if (f7_zero) ctrl_d = ALU_SLL;  else illegal_d = 1'b1;
               3'b010: if (f7_zero) ctrl_d = ALU_SLT;  else illegal_d = 1'b1;
               3'b011: if (f7_zero) ctrl_d = ALU_SLTU; else illegal_d = 1'b1;
               3'b100: if (f7_zero) ctrl_d = ALU_XOR;  else illegal_d = 1'b1;
               3'b101: begin
                  if (f7_zero)     ctrl_d = ALU_SRL;
                  else if (f7_alt) ctrl_d = ALU_SRA;
                  else             illegal_d = 1'b1;
               end
`endif
               3'b110: if (f7_zero) ctrl_d = ALU_OR;  else illegal_d = 1'b1;
               3'b111: if (f7_zero) ctrl_d = ALU_AND; else illegal_d = 1'b1;
               default: illegal_d = 1'b1;
            endcase
         end
         2'b11: begin
            // Immediate forms: funct7 is part of the immediate except for shifts.
            case (funct3)
               3'b000: ctrl_d = ALU_ADD;
`ifdef ALU_CTRL_EXT_EN
               3'b001: if (f7_zero) ctrl_d = ALU_SLL; else illegal_d = 1'b1;
               3'b010: ctrl_d = ALU_SLT;
               3'b011: ctrl_d = ALU_SLTU;
               3'b100: ctrl_d = ALU_XOR;
               3'b101: begin
                  if (f7_zero)     ctrl_d = ALU_SRL;
                  else if (f7_alt) ctrl_d = ALU_SRA;
                  else             illegal_d = 1'b1;
               end
`endif
               3'b110: ctrl_d = ALU_OR;
               3'b111: ctrl_d = ALU_AND;
               default: illegal_d = 1'b1;
            endcase
         end
         default: begin
            ctrl_d    = ALU_ADD;
            illegal_d = 1'b0;
         end
      endcase
   end

   assign sticky_d = sticky_q | illegal_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q      <= ALU_ADD;
         illegal_r_q <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         ctrl_q      <= ctrl_d;
         illegal_r_q <= illegal_d;
         sticky_q    <= sticky_d;
      end
   end

   assign alu_control    = ctrl_d;
   assign illegal        = illegal_d;
   assign alu_control_q  = ctrl_q;
   assign illegal_q      = illegal_r_q;
   assign illegal_sticky = sticky_q;

endmodule

// File: tb/tb_alu_control_dec.sv
// tb/tb_alu_control_dec.sv - randomized self-checking bench for alu_control_dec against a rule-table model
// Honors ALU_CTRL_EXT_EN the same way the design does.
module tb_alu_control_dec;

   logic       clk;
   logic       rst;
   logic [1:0] aluop;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic [3:0] alu_control;
   logic       illegal;
   logic [3:0] alu_control_q;
   logic       illegal_q;
   logic       illegal_sticky;

   int total;
   int bad;

   alu_control_dec dut (
      .clk            (clk),
      .rst            (rst),
      .aluop          (aluop),
      .funct7         (funct7),
      .funct3         (funct3),
      .alu_control    (alu_control),
      .illegal        (illegal),
      .alu_control_q  (alu_control_q),
      .illegal_q      (illegal_q),
      .illegal_sticky (illegal_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One legal encoding: f7req < 0 means funct7 is not consulted.
   typedef struct {
      logic [1:0] op;
      logic [2:0] f3;
      int         f7req;
      logic [3:0] res;
   } rule_t;

   rule_t rules[$];

   logic [3:0] exp_q;
   logic       exp_il_q;
   logic       exp_st;
   logic       regs_known;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic rule_t mk(input logic [1:0] op, input logic [2:0] f3, input int f7req,
                                input logic [3:0] res);
      rule_t r;
      r.op = op; r.f3 = f3; r.f7req = f7req; r.res = res;
      return r;
   endfunction

   task automatic model(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                        output logic [3:0] ec, output logic ei);
      ec = 4'd2;
      ei = 1'b1;
      if (op == 2'b00) begin
         ec = 4'd2; ei = 1'b0;
      end else if (op == 2'b01) begin
         ec = 4'd6; ei = 1'b0;
      end else begin
         foreach (rules[i]) begin
            if (rules[i].op == op && rules[i].f3 == f3 &&
                (rules[i].f7req < 0 || int'(f7) == rules[i].f7req)) begin
               ec = rules[i].res;
               ei = 1'b0;
            end
         end
      end
   endtask

   task automatic apply(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                        input logic r);
      logic [3:0] ec;
      logic       ei;
      @(posedge clk);
      #1;
      if (regs_known) begin
         check("alu_control_q", 32'(alu_control_q), 32'(exp_q));
         check("illegal_q", 32'(illegal_q), 32'(exp_il_q));
         check("illegal_sticky", 32'(illegal_sticky), 32'(exp_st));
      end
      aluop = op; funct7 = f7; funct3 = f3; rst = r;
      #1;
      model(op, f7, f3, ec, ei);
      check("alu_control", 32'(alu_control), 32'(ec));
      check("illegal", 32'(illegal), 32'(ei));
      if (r) begin
         exp_q = 4'd2; exp_il_q = 1'b0; exp_st = 1'b0; regs_known = 1'b1;
      end else if (regs_known) begin
         exp_q = ec; exp_il_q = ei; exp_st = exp_st | ei;
      end
   endtask

   initial begin
      logic [1:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      total = 0; bad = 0; regs_known = 1'b0;
      exp_q = 4'd2; exp_il_q = 1'b0; exp_st = 1'b0;
      rst = 1'b1; aluop = 2'b00; funct7 = 7'd0; funct3 = 3'd0;

      rules.push_back(mk(2'b10, 3'b000, 0,    4'b0010));
      rules.push_back(mk(2'b10, 3'b000, 32,   4'b0110));
      rules.push_back(mk(2'b10, 3'b110, 0,    4'b0001));
      rules.push_back(mk(2'b10, 3'b111, 0,    4'b0000));
      rules.push_back(mk(2'b11, 3'b000, -1,   4'b0010));
      rules.push_back(mk(2'b11, 3'b110, -1,   4'b0001));
      rules.push_back(mk(2'b11, 3'b111, -1,   4'b0000));
`ifdef ALU_CTRL_EXT_EN
      rules.push_back(mk(2'b10, 3'b001, 0,    4'b0011));
      rules.push_back(mk(2'b10, 3'b010, 0,    4'b0111));
      rules.push_back(mk(2'b10, 3'b011, 0,    4'b1001));
      rules.push_back(mk(2'b10, 3'b100, 0,    4'b0100));
      rules.push_back(mk(2'b10, 3'b101, 0,    4'b0101));
      rules.push_back(mk(2'b10, 3'b101, 32,   4'b1000));
      rules.push_back(mk(2'b11, 3'b001, 0,    4'b0011));
      rules.push_back(mk(2'b11, 3'b010, -1,   4'b0111));
      rules.push_back(mk(2'b11, 3'b011, -1,   4'b1001));
      rules.push_back(mk(2'b11, 3'b100, -1,   4'b0100));
      rules.push_back(mk(2'b11, 3'b101, 0,    4'b0101));
      rules.push_back(mk(2'b11, 3'b101, 32,   4'b1000));
`endif

      apply(2'b00, 7'd0, 3'd0, 1'b1);
      apply(2'b00, 7'bx, 3'bx, 1'b0);
      apply(2'b01, 7'bx, 3'bx, 1'b0);
      apply(2'b10, 7'b0000000, 3'b000, 1'b0);
      apply(2'b10, 7'b0100000, 3'b000, 1'b0);
      apply(2'b10, 7'b0000000, 3'b111, 1'b0);
      apply(2'b10, 7'b0000000, 3'b110, 1'b0);
      apply(2'b10, 7'b0100000, 3'b101, 1'b0);
      apply(2'b11, 7'b0100000, 3'b000, 1'b0);
      apply(2'b10, 7'b0000000, 3'b011, 1'b0);
      apply(2'b10, 7'b0000000, 3'b100, 1'b0);
      apply(2'b10, 7'b0000001, 3'b000, 1'b0);
      apply(2'b10, 7'b0000000, 3'b000, 1'b0);
      apply(2'b01, 7'b0000000, 3'b000, 1'b0);
      apply(2'b10, 7'b0000001, 3'b000, 1'b1);
      apply(2'b00, 7'b0000000, 3'b000, 1'b0);

      for (int n = 0; n < 400; n++) begin
         op = 2'($urandom_range(0, 3));
         f3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: f7 = 7'b0000000;
            1: f7 = 7'b0100000;
            2: f7 = 7'(1 << $urandom_range(0, 6));
            default: f7 = 7'($urandom);
         endcase
         apply(op, f7, f3, ($urandom_range(0, 24) == 0));
      end
      apply(2'b00, 7'd0, 3'd0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
